// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding fetch stage with 2-entry instruction queue
// Optional misaligned-pc fault entries when IFETCH_ALIGN_CHECK_EN is defined.
module instruction_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        redirect,
   output logic        fetch_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_fault,
   input  logic        id_ready
);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } entry_t;

   state_t      state, state_next;
   logic [1:0]  count, count_after;
   logic [31:0] req_pc;
   entry_t      q [2];
   entry_t      q_n [2];
   logic        push, pop, accept, misaligned, issue, fault_push;
   logic        push_slot, fault_slot;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign misaligned = (pc[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      push        = (state == REQ) && imem_ack && !redirect;
      pop         = if_valid && id_ready && !redirect;
      count_after = count + {1'b0, push} - {1'b0, pop};
      accept      = ((state == IDLE) || ((state == REQ) && imem_ack)) &&
                    (count_after < 2'd2) && !redirect;
      issue       = accept && !misaligned;
      fault_push  = accept && misaligned;
      fetch_stall = rst && !accept;
      // A request is only ever issued with room left, so an acked word always fits.
      push_slot   = count[0] ^ pop;
      fault_slot  = count_after[0];
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (issue) state_next = REQ;
         REQ: begin
            if (redirect)      state_next = imem_ack ? IDLE : DROP;
            else if (imem_ack) state_next = issue ? REQ : IDLE;
         end
         DROP: if (imem_ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      q_n = q;
      if (pop)        q_n[0] = q[1];
      if (push)       q_n[push_slot] = {req_pc, imem_rdata, 1'b0};
      if (fault_push) q_n[fault_slot] = {pc, 32'h0000_0000, 1'b1};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         count     <= 2'd0;
         imem_addr <= 32'h0;
         req_pc    <= 32'h0;
         for (int i = 0; i < 2; i++) q[i] <= '0;
      end else begin
         state <= state_next;
         count <= redirect ? 2'd0 : count_after + {1'b0, fault_push};
         q     <= q_n;
         if (issue) begin
            imem_addr <= {pc[31:2], 2'b00};
            req_pc    <= pc;
         end
      end
   end

   // DROP keeps the request up so the memory can finish the abandoned access.
   assign imem_req = (state != IDLE);
   assign if_valid = (count != 2'd0);
   assign if_pc    = q[0].pc;
   assign if_instr = q[0].instr;
   assign if_fault = q[0].fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc = 32'h0;
   logic        redirect = 1'b0;
   logic        fetch_stall, imem_req, imem_ack = 1'b0;
   logic [31:0] imem_addr, imem_rdata, if_instr, if_pc;
   logic        if_valid, if_fault;
   logic        id_ready = 1'b0;

   instruction_fetch dut (
      .clk(clk), .rst(rst), .pc(pc), .redirect(redirect),
      .fetch_stall(fetch_stall), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_fault(if_fault),
      .id_ready(id_ready)
   );

   always #5 clk = ~clk;

`ifdef IFETCH_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   bit override = 1'b0;
   int wait_states = 0;
   int wcnt = 0;
   assign imem_rdata = override ? 32'hDEAD_BEEF : mem_word(imem_addr);

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } ent_t;

   ent_t        mq[$];
   ent_t        dlv[$];
   bit          m_out = 1'b0, m_drop = 1'b0;
   logic [31:0] m_addr = 32'h0, m_pc = 32'h0;
   bit          s_stall = 1'b0, s_req = 1'b0, s_ack = 1'b0, s_rst = 1'b0;
   int          stall_hits = 0;

   // Reference model: one outstanding request plus an ordered queue of deliverable words.
   always @(negedge clk) begin
      bit   exp_valid, ack_data, popm, can, acc;
      int   nsize;
      ent_t e;
      s_stall = fetch_stall; s_req = imem_req; s_ack = imem_ack; s_rst = rst;
      if (!rst) begin
         chk("rst_req", imem_req, 0);
         chk("rst_addr", imem_addr, 0);
         chk("rst_valid", if_valid, 0);
         chk("rst_pc", if_pc, 0);
         chk("rst_instr", if_instr, 0);
         chk("rst_fault", if_fault, 0);
         chk("rst_stall", fetch_stall, 0);
         mq.delete();
         m_out = 0; m_drop = 0; m_addr = 0; m_pc = 0;
      end else begin
         exp_valid = (mq.size() != 0);
         chk("mon_valid", if_valid, exp_valid);
         if (exp_valid) begin
            chk("mon_pc", if_pc, mq[0].pc);
            chk("mon_instr", if_instr, mq[0].instr);
            chk("mon_fault", if_fault, mq[0].fault);
         end
         chk("mon_req", imem_req, m_out);
         if (m_out) chk("mon_addr", imem_addr, m_addr);
         ack_data = m_out && !m_drop && imem_ack && !redirect;
         popm     = exp_valid && id_ready && !redirect;
         nsize    = mq.size() + int'(ack_data) - int'(popm);
         can      = !m_out || (imem_ack && !m_drop);
         acc      = can && (nsize < 2) && !redirect;
         chk("mon_stall", fetch_stall, !acc);
         if (fetch_stall) stall_hits++;
         if (popm) dlv.push_back(mq[0]);
         if (redirect) begin
            mq.delete();
            if (m_out && imem_ack) begin m_out = 0; m_drop = 0; end
            else if (m_out) m_drop = 1;
         end else begin
            if (popm) void'(mq.pop_front());
            if (ack_data) begin
               e.pc = m_pc; e.instr = imem_rdata; e.fault = 0;
               mq.push_back(e);
            end
            if (m_out && imem_ack) begin m_out = 0; m_drop = 0; end
            if (acc) begin
               if (ALIGN_EN && pc[1:0] != 2'b00) begin
                  e.pc = pc; e.instr = 32'h0; e.fault = 1;
                  mq.push_back(e);
               end else begin
                  m_out = 1; m_drop = 0;
                  m_addr = {pc[31:2], 2'b00}; m_pc = pc;
               end
            end
         end
      end
   end

   // One clock: PC advances when the previous cycle was not stalled; memory acks after wait_states.
   task automatic cycle();
      bit adv, pr, pa;
      @(posedge clk);
      adv = s_rst && !s_stall; pr = s_req; pa = s_ack;
      #1;
      redirect = 1'b0;
      if (adv) pc = pc + 32'd4;
      if (!pr || pa) wcnt = 0; else wcnt++;
      imem_ack = imem_req && (wcnt >= wait_states);
   endtask

   task automatic do_reset(input logic [31:0] start_pc, input int ws, input bit rdy);
      rst = 1'b0; imem_ack = 1'b0; redirect = 1'b0; override = 1'b0;
      id_ready = 1'b0; wcnt = 0;
      @(negedge clk);
      @(posedge clk);
      #1;
      pc = start_pc; wait_states = ws; id_ready = rdy;
      rst = 1'b1;
      stall_hits = 0;
      dlv.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Asynchronous reset in the middle of an outstanding request.
      do_reset(32'h40, 1, 1'b0);
      cycle(); cycle(); cycle();
      #1;
      chk("pre_rst_req", imem_req, 1);
      chk("pre_rst_valid", if_valid, 1);
      chk("pre_rst_pc", if_pc, 32'h40);
      #1 rst = 1'b0;
      #1;
      chk("async_req", imem_req, 0);
      chk("async_addr", imem_addr, 0);
      chk("async_valid", if_valid, 0);
      chk("async_pc", if_pc, 0);
      chk("async_stall", fetch_stall, 0);
      do_reset(32'h0, 10, 1'b0);
      #1 chk("rel_stall", fetch_stall, 0);
      cycle();
      #1;
      chk("rel_req", imem_req, 1);
      chk("rel_addr", imem_addr, 32'h0);

      // Zero-wait stream with decode always ready.
      do_reset(32'h0, 0, 1'b1);
      cycle(); cycle();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stream_valid", if_valid, 1);
         chk("stream_pc", if_pc, 32'(i * 4));
         chk("stream_instr", if_instr, mem_word(32'(i * 4)));
         cycle();
      end
      chk("stream_no_stall", 32'(stall_hits), 0);

      // Backpressure: queue fills, then drains in order.
      do_reset(32'h0, 0, 1'b0);
      cycle(); cycle(); cycle();
      #1;
      chk("bp_stall", fetch_stall, 1);
      chk("bp_req", imem_req, 0);
      chk("bp_head", if_pc, 32'h0);
      cycle();
      #1;
      chk("bp_req_hold", imem_req, 0);
      id_ready = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      chk("bp_count", 32'(dlv.size() >= 6), 1);
      for (int i = 0; i < 6; i++)
         if (i < dlv.size()) begin
            chk("bp_order_pc", dlv[i].pc, 32'(i * 4));
            chk("bp_order_instr", dlv[i].instr, mem_word(32'(i * 4)));
         end

      // Three wait states.
      do_reset(32'h0040_0000, 3, 1'b1);
      cycle();
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ws_req", imem_req, 1);
         chk("ws_addr", imem_addr, 32'h0040_0000);
         chk("ws_stall", fetch_stall, 1);
         chk("ws_noack", imem_ack, 0);
         cycle();
      end
      #1 chk("ws_ack", imem_ack, 1);
      cycle();
      #1;
      chk("ws_valid", if_valid, 1);
      chk("ws_pc", if_pc, 32'h0040_0000);
      chk("ws_instr", if_instr, mem_word(32'h0040_0000));

      // Redirect while a request is in flight.
      do_reset(32'h0, 2, 1'b0);
      cycle(); cycle(); cycle(); cycle();
      pc = 32'h100; redirect = 1'b1; override = 1'b1;
      #1;
      chk("rd_valid_before", if_valid, 1);
      chk("rd_stall", fetch_stall, 1);
      cycle();
      #1;
      chk("rd_flushed", if_valid, 0);
      chk("rd_drop_req", imem_req, 1);
      chk("rd_drop_stall", fetch_stall, 1);
      cycle();
      #1;
      chk("rd_drop_ack", imem_ack, 1);
      chk("rd_drop_ack_stall", fetch_stall, 1);
      id_ready = 1'b1;
      cycle();
      override = 1'b0;
      #1;
      chk("rd_idle_req", imem_req, 0);
      chk("rd_accept", fetch_stall, 0);
      chk("rd_discarded", if_valid, 0);
      cycle();
      #1;
      chk("rd_new_req", imem_req, 1);
      chk("rd_new_addr", imem_addr, 32'h100);
      for (int i = 0; i < 20 && dlv.size() == 0; i++) cycle();
      chk("rd_delivered", 32'(dlv.size() != 0), 1);
      if (dlv.size() != 0) begin
         chk("rd_first_pc", dlv[0].pc, 32'h100);
         chk("rd_first_instr", dlv[0].instr, mem_word(32'h100));
      end

      // Misaligned pc.
      do_reset(32'h102, 0, 1'b0);
      cycle();
      #1;
`ifdef IFETCH_ALIGN_CHECK_EN
      chk("mis_req", imem_req, 0);
      chk("mis_valid", if_valid, 1);
      chk("mis_pc", if_pc, 32'h102);
      chk("mis_instr", if_instr, 32'h0);
      chk("mis_fault", if_fault, 1);
`else
      chk("mis_req", imem_req, 1);
      chk("mis_addr", imem_addr, 32'h100);
      cycle();
      #1;
      chk("mis_valid", if_valid, 1);
      chk("mis_pc", if_pc, 32'h102);
      chk("mis_instr", if_instr, mem_word(32'h100));
      chk("mis_fault", if_fault, 0);
`endif
      cycle(); cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the program counter and decode. Samples the current `pc`, issues a single-outstanding request to instruction memory, and buffers returned words with their addresses in a 2-entry queue. The queue feeds decode over a valid/ready handshake. `fetch_stall` tells the PC control logic when the PC must be held. `redirect` discards in-flight and buffered fetches after a jump or branch.

## Interface
- No parameters; widths fixed at 32-bit address and instruction.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pc` in 32: current fetch address from the program counter.
- `redirect` in 1: asserted for one cycle after the PC loads a non-sequential target (jump, jr, branch taken).
- `fetch_stall` out 1: PC must not advance this cycle.
- `imem_req` out 1: memory request valid.
- `imem_addr` out 32: word address of the request.
- `imem_ack` in 1: memory returns data this cycle.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `if_valid` out 1: queue head valid for decode.
- `if_instr` out 32: head instruction.
- `if_pc` out 32: head address.
- `if_fault` out 1: head entry is a misaligned-fetch fault.
- `id_ready` in 1: decode consumes the head this cycle.

## Operation
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding.
  - DROP: request outstanding, result to be discarded.
- Handshake events:
  - push = (state==REQ && imem_ack && !redirect).
  - pop = if_valid && id_ready && !redirect.
  - count_next = count + push − pop.
- accept = (state==IDLE || (state==REQ && imem_ack)) && count_next<2 && !redirect.
- fetch_stall = !accept, combinational.
- On accept:
  - state→REQ.
  - imem_addr←{pc[31:2],2'b00}; the request's pc is also latched.
  - imem_req=1.
- REQ with imem_ack and no accept → IDLE, imem_req←0.
- imem_req and imem_addr hold stable from issue until the ack edge.
- Queue:
  - 2-entry FIFO of {pc, instr, fault}.
  - Head drives if_pc/if_instr/if_fault.
  - if_valid = count≠0.
  - Simultaneous push and pop on a full queue is legal; count is unchanged.
- Redirect (priority over everything):
  - Queue count←0.
  - REQ without ack → DROP, with imem_req held.
  - REQ with ack → data discarded, state→IDLE.
  - No pc accepted in the redirect cycle.
- DROP:
  - imem_req held high until imem_ack.
  - Data is discarded on ack; state→IDLE.
  - Further redirects in DROP have no extra effect.
- Reset values (rst low, asynchronous):
  - state IDLE, count 0, FIFO storage 0.
  - imem_req 0, imem_addr 0.
  - if_valid 0, if_instr 0, if_pc 0, if_fault 0.
  - fetch_stall 0.
- Reset mid-request drops the outstanding transaction; memory must tolerate an abandoned request.

## Timing
- pc accepted at edge N → imem_req high from cycle N+1.
- Ack in the same cycle as req (zero wait) → entry pushed at that edge; if_valid the following cycle.
- Minimum pc-accept to if_valid latency is 2 cycles.
- Zero-wait memory with decode always ready sustains one instruction per cycle.
- With k wait states, throughput is one instruction per k+1 cycles.
- Pop takes effect at the edge where if_valid && id_ready.
- The head is registered; there is no combinational path from id_ready to if_*.
- fetch_stall depends combinationally on imem_ack, id_ready and redirect.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - An accepted pc with pc[1:0]≠0 issues no memory request.
  - The fault entry {pc, 32'h00000000, fault=1} is pushed at the accept edge.
  - State stays IDLE.
  - Normal entries carry fault=0.
- Not defined:
  - pc[1:0] ignored; address forced to word alignment.
  - if_fault tied 0.

## Test plan
- Reset: drive rst low mid-REQ with imem_ack low → outputs immediately at reset values. Release → accept pc=0 at first edge, imem_addr=0, imem_req=1 the next cycle.
- Zero-wait stream: pc 0x0,0x4,0x8,0xC with imem_ack always high and id_ready=1 → if_valid continuous from cycle 2; if_pc/if_instr in order; fetch_stall never high.
- Backpressure: id_ready=0, zero-wait memory:
  - After 2 pushes, fetch_stall=1 and no new request.
  - Raise id_ready → one pop per cycle, order preserved, no loss or duplication.
- Wait states: imem_ack after 3 cycles → imem_req/imem_addr stable 3 cycles; fetch_stall high throughout; entry 0x00400000 appears the cycle after the ack.
- Redirect in flight: redirect while REQ, ack 2 cycles later with 0xDEADBEEF:
  - Queue empties next cycle; word discarded.
  - Target pc 0x100 is accepted only after the DROP ack.
  - First delivered if_pc=0x100.
- Misalignment (macro on): pc=0x102 → no imem_req; entry if_pc=0x102, if_instr=0, if_fault=1. With macro off → imem_addr=0x100, if_fault=0.
